pad_port_ctrl: RTL and testbench
================================

PAD_PORT_CTRL -- requirements
Module: pad_port_ctrl

Interface
REQ-001 Parameter NB_PINS, default 16: number of pad pins handled.
REQ-002 Parameter FILT_CNT_W, default 4: glitch-filter counter and threshold width.
REQ-003 clk_in  input  1  system clock; all flops on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pad_pmux_din  input  NB_PINS  raw, unsynchronised pad input levels.
REQ-006 pmux_pad_ie  input  NB_PINS  per-pin input enable; 0 forces the pin's conditioned input to 0.
REQ-007 filt_thresh  input  FILT_CNT_W  glitch-filter threshold T, quasi-static.
REQ-008 irq_rise_en  input  NB_PINS  per-pin rising-edge interrupt enable.
REQ-009 irq_fall_en  input  NB_PINS  per-pin falling-edge interrupt enable.
REQ-010 irq_clr  input  NB_PINS  write-1-to-clear pulse for irq_pending, one clk_in wide.
REQ-011 port_din  output  NB_PINS  synchronised, filtered pin levels (registered).
REQ-012 irq_pending  output  NB_PINS  latched edge-event flags (registered).
REQ-013 irq  output  1  OR-reduction of irq_pending.

Function
REQ-014 Each pin SHALL pass through a two-flop synchroniser (sync1, sync2).
REQ-015 Masked level m SHALL be sync2 AND pmux_pad_ie, evaluated per pin.
REQ-016 Each pin SHALL have a FILT_CNT_W-bit counter cnt.
REQ-017 Filter update at each edge, when m equals port_din: cnt <= 0.
REQ-018 Filter update at each edge, when m differs and cnt >= filt_thresh: port_din <= m and cnt <= 0.
REQ-019 Filter update at each edge, when m differs and cnt < filt_thresh: cnt <= cnt + 1.
REQ-020 The cnt >= filt_thresh comparison guarantees no counter wrap, including when T is lowered mid-count; cnt SHALL never exceed 2^FILT_CNT_W-1.
REQ-021 Latency: a stable pad change sampled at edge 1 SHALL appear on port_din at edge T+3; a pulse whose masked level lasts <= T edges SHALL NOT reach port_din.
REQ-022 A previous-value flop din_d SHALL track port_din.
REQ-023 Rising event: port_din=1 and din_d=0; falling event: port_din=0 and din_d=1.
REQ-024 irq_pending[i] <= (irq_pending[i] AND NOT irq_clr[i]) OR (rise[i] AND irq_rise_en[i]) OR (fall[i] AND irq_fall_en[i]).
REQ-025 When an event and irq_clr coincide on the same pin and cycle, set SHALL win.
REQ-026 Deasserting pmux_pad_ie on a high pin SHALL be filtered like any other falling transition and MAY raise a falling event.
REQ-027 irq SHALL be combinational OR of irq_pending flops, with no extra latency.
REQ-028 Enables SHALL gate event capture only; clearing an enable SHALL NOT clear irq_pending.

Reset
REQ-029 On rst_n low, sync1, sync2, cnt, port_din, din_d and irq_pending SHALL clear to 0 asynchronously; irq SHALL read 0.
REQ-030 After rst_n deasserts, the first input sample SHALL be taken on the first clk_in rising edge; reset mid-filtering SHALL discard the partial count.

Configuration
REQ-031 Macro PAD_PORT_CTRL_GLITCH_FILTER_EN.
REQ-032 With PAD_PORT_CTRL_GLITCH_FILTER_EN defined: counters exist and filt_thresh is honoured.
REQ-033 Without PAD_PORT_CTRL_GLITCH_FILTER_EN: no counters; port_din <= m every edge (behaves as T=0, latency 3 edges); filt_thresh is ignored; the port is kept.

Verification
REQ-034 T=0, pin0 0->1 held -> port_din[0]=1 at edge 3; irq_pending[0]=1 one edge later if irq_rise_en[0]=1.
REQ-035 T=3, pin5 high for 3 edges then low -> port_din[5] stays 0, no pending; held 4 edges -> port_din[5]=1 at edge 6.
REQ-036 pmux_pad_ie[2]=0, pin2 toggling -> port_din[2]=0, no pending; set ie with pin high -> rise after T+1 edges.
REQ-037 irq_clr[7] in the same cycle as a pin7 falling event with irq_fall_en[7]=1 -> irq_pending[7] remains 1; a later irq_clr[7] alone -> 0; irq drops when all flags are clear.
REQ-038 T=15 with cnt=10, then T lowered to 4 -> port_din updates on the next edge, no wrap.
REQ-039 rst_n asserted mid-count and with pending set -> all outputs 0 immediately; after release, T=0 path works again.

Source files
------------

// File: rtl/pad_port_ctrl.sv
// ============================================================================
// Module      : pad_port_ctrl
// Description : Pad input port conditioning (synchroniser, input-enable
//               masking, optional glitch filter) with edge-event interrupts.
//               Filter built only when PAD_PORT_CTRL_GLITCH_FILTER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_port_ctrl #(
    parameter int NB_PINS    = 16,
    parameter int FILT_CNT_W = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [NB_PINS-1:0]    pad_pmux_din,
    input  logic [NB_PINS-1:0]    pmux_pad_ie,
    input  logic [FILT_CNT_W-1:0] filt_thresh,
    input  logic [NB_PINS-1:0]    irq_rise_en,
    input  logic [NB_PINS-1:0]    irq_fall_en,
    input  logic [NB_PINS-1:0]    irq_clr,
    output logic [NB_PINS-1:0]    port_din,
    output logic [NB_PINS-1:0]    irq_pending,
    output logic                  irq
);

    logic [NB_PINS-1:0] sync1;
    logic [NB_PINS-1:0] sync2;
    logic [NB_PINS-1:0] masked;
    logic [NB_PINS-1:0] din_d;
    logic [NB_PINS-1:0] rise;
    logic [NB_PINS-1:0] fall;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pad_pmux_din;
            sync2 <= sync1;
        end
    end

    // Masking after the synchroniser makes an ie drop look like a normal falling input.
    assign masked = sync2 & pmux_pad_ie;

`ifdef PAD_PORT_CTRL_GLITCH_FILTER_EN
    logic [FILT_CNT_W-1:0] cnt [NB_PINS];

    // cnt only increments while below the threshold, so it can never wrap.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            port_din <= '0;
            for (int i = 0; i < NB_PINS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_PINS; i++) begin
                if (masked[i] == port_din[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= filt_thresh) begin
                    port_din[i] <= masked[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + FILT_CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_filt_thresh;
    assign unused_filt_thresh = ^filt_thresh;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            port_din <= '0;
        end else begin
            port_din <= masked;
        end
    end
`endif

    assign rise = port_din & ~din_d;
    assign fall = ~port_din & din_d;

    // Set has priority over a coincident clear.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            din_d       <= '0;
            irq_pending <= '0;
        end else begin
            din_d       <= port_din;
            irq_pending <= (irq_pending & ~irq_clr)
                         | (rise & irq_rise_en)
                         | (fall & irq_fall_en);
        end
    end

    assign irq = |irq_pending;

endmodule

`default_nettype wire

// File: tb/tb_pad_port_ctrl.sv
// ============================================================================
// Module      : tb_pad_port_ctrl
// Description : Directed self-checking bench for pad_port_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pad_port_ctrl;

`ifdef PAD_PORT_CTRL_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk_in;
    logic        rst_n;
    logic [15:0] pad_pmux_din;
    logic [15:0] pmux_pad_ie;
    logic [3:0]  filt_thresh;
    logic [15:0] irq_rise_en;
    logic [15:0] irq_fall_en;
    logic [15:0] irq_clr;
    logic [15:0] port_din;
    logic [15:0] irq_pending;
    logic        irq;

    int n_checks;
    int n_pass;

    pad_port_ctrl #(
        .NB_PINS    (16),
        .FILT_CNT_W (4)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .pad_pmux_din (pad_pmux_din),
        .pmux_pad_ie  (pmux_pad_ie),
        .filt_thresh  (filt_thresh),
        .irq_rise_en  (irq_rise_en),
        .irq_fall_en  (irq_fall_en),
        .irq_clr      (irq_clr),
        .port_din     (port_din),
        .irq_pending  (irq_pending),
        .irq          (irq)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        pad_pmux_din = '0;
        pmux_pad_ie  = '1;
        filt_thresh  = 4'd0;
        irq_rise_en  = '1;
        irq_fall_en  = '0;
        irq_clr      = '0;

        // Reset state
        tick(2);
        check_eq("rst_port_din", 32'(port_din), 32'h0);
        check_eq("rst_pending", 32'(irq_pending), 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        // T=0 latency on pin0
        pad_pmux_din[0] = 1'b1;
        tick(2);
        check_eq("t0_edge2_din0", 32'(port_din[0]), 32'h0);
        tick(1);
        check_eq("t0_edge3_din0", 32'(port_din[0]), 32'h1);
        check_eq("t0_edge3_pend0", 32'(irq_pending[0]), 32'h0);
        tick(1);
        check_eq("t0_edge4_pend0", 32'(irq_pending[0]), 32'h1);
        check_eq("t0_edge4_irq", 32'(irq), 32'h1);
        irq_clr[0] = 1'b1;
        tick(1);
        irq_clr[0] = 1'b0;
        check_eq("t0_clr_pend0", 32'(irq_pending[0]), 32'h0);
        check_eq("t0_clr_irq", 32'(irq), 32'h0);

        // T=3 glitch on pin5: 3 edges rejected, 4 edges accepted
        filt_thresh = 4'd3;
        pad_pmux_din[5] = 1'b1;
        tick(3);
        pad_pmux_din[5] = 1'b0;
        tick(6);
        check_eq("glitch_din5", 32'(port_din[5]), 32'h0);
        check_eq("glitch_pend5", 32'(irq_pending[5]), FILT ? 32'h0 : 32'h1);
        irq_clr = '1;
        tick(1);
        irq_clr = '0;
        tick(2);
        pad_pmux_din[5] = 1'b1;
        tick(5);
        check_eq("held_edge5_din5", 32'(port_din[5]), FILT ? 32'h0 : 32'h1);
        tick(1);
        check_eq("held_edge6_din5", 32'(port_din[5]), 32'h1);
        tick(2);

        // Input enable masking on pin2, T=2
        filt_thresh    = 4'd2;
        pmux_pad_ie[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pad_pmux_din[2] = ~pad_pmux_din[2];
            tick(1);
        end
        check_eq("ie_off_din2", 32'(port_din[2]), 32'h0);
        check_eq("ie_off_pend2", 32'(irq_pending[2]), 32'h0);
        pad_pmux_din[2] = 1'b1;
        tick(3);
        pmux_pad_ie[2] = 1'b1;
        tick(FILT ? 2 : 0);
        check_eq("ie_on_pre_din2", 32'(port_din[2]), 32'h0);
        tick(1);
        check_eq("ie_on_din2", 32'(port_din[2]), 32'h1);
        tick(1);
        check_eq("ie_on_pend2", 32'(irq_pending[2]), 32'h1);

        irq_clr = '1;
        tick(1);
        irq_clr = '0;
        check_eq("clr_all_irq", 32'(irq), 32'h0);

        // Pin7: clear coinciding with falling event, set wins
        filt_thresh    = 4'd0;
        irq_rise_en[7] = 1'b0;
        irq_fall_en[7] = 1'b1;
        pad_pmux_din[7] = 1'b1;
        tick(5);
        check_eq("p7_high_din7", 32'(port_din[7]), 32'h1);
        check_eq("p7_high_pend7", 32'(irq_pending[7]), 32'h0);
        pad_pmux_din[7] = 1'b0;
        tick(3);
        check_eq("p7_fall_din7", 32'(port_din[7]), 32'h0);
        irq_clr[7] = 1'b1;
        tick(1);
        irq_clr[7] = 1'b0;
        check_eq("p7_setwins_pend7", 32'(irq_pending[7]), 32'h1);
        check_eq("p7_setwins_irq", 32'(irq), 32'h1);
        irq_fall_en[7] = 1'b0;
        tick(2);
        check_eq("p7_en_off_pend7", 32'(irq_pending[7]), 32'h1);
        irq_clr[7] = 1'b1;
        tick(1);
        irq_clr[7] = 1'b0;
        check_eq("p7_clr_pend7", 32'(irq_pending[7]), 32'h0);
        check_eq("p7_clr_irq", 32'(irq), 32'h0);

        // Pin9: threshold lowered mid-count
        filt_thresh     = 4'd15;
        pad_pmux_din[9] = 1'b1;
        tick(12);
        check_eq("lower_pre_din9", 32'(port_din[9]), FILT ? 32'h0 : 32'h1);
        filt_thresh = 4'd4;
        tick(1);
        check_eq("lower_post_din9", 32'(port_din[9]), 32'h1);
        tick(2);
        check_eq("lower_pend9", 32'(irq_pending[9]), 32'h1);

        // Asynchronous reset mid-count with pending set
        filt_thresh      = 4'd15;
        pad_pmux_din[11] = 1'b1;
        tick(6);
        check_eq("prerst_irq", 32'(irq), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_port_din", 32'(port_din), 32'h0);
        check_eq("midrst_pending", 32'(irq_pending), 32'h0);
        check_eq("midrst_irq", 32'(irq), 32'h0);
        filt_thresh = 4'd0;
        #1;
        rst_n = 1'b1;
        tick(2);
        check_eq("postrst_edge2_din11", 32'(port_din[11]), 32'h0);
        tick(1);
        check_eq("postrst_edge3_din11", 32'(port_din[11]), 32'h1);
        tick(1);
        check_eq("postrst_edge4_pend11", 32'(irq_pending[11]), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
